// File: rtl/fifo_arb_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : fifo_arb_pkg
// Brief    : Shared state encoding and ID-width helper for the FIFO write arbiter
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  // A single requester still needs one ID bit so the FIFO word keeps a tag field.
  function automatic int idw_f(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_write_arbiter_rr_picker.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : rr_picker
// Brief    : Round-robin picker: rotate after last_grant, priority-encode, un-rotate
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  last_grant_i,
  output logic            any_req_o,
  output logic [IDW-1:0]  pick_o
);

  logic [NREQ-1:0] rot;
  int              start;
  int              off;

  assign any_req_o = |req_i;

  always_comb begin
    start = (int'(last_grant_i) + 1) % NREQ;
    rot   = '0;
    for (int k = 0; k < NREQ; k++) begin
      rot[k] = req_i[(start + k) % NREQ];
    end
    // Descending scan so the lowest rotated position wins.
    off = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) off = k;
    end
    pick_o = IDW'((start + off) % NREQ);
  end

endmodule
`default_nettype wire

// File: rtl/fifo_write_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : fifo_write_arbiter
// Brief    : Round-robin, burst-limited sharing of one FIFO write port; tags words with source ID
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST      = 4,
  localparam int IDW       = idw_f(NREQ),
  localparam int CW        = $clog2(BURST + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*DATA_WIDTH-1:0] req_data,
  output logic [NREQ-1:0]            req_ready,
  output logic                       fifo_write,
  output logic [IDW+DATA_WIDTH-1:0]  fifo_datain,
  input  logic                       fifo_full,
  output logic [IDW-1:0]             grant_id,
  output logic                       busy
);

  arb_state_e      state_q, state_d;
  logic [IDW-1:0]  grant_q, grant_d;
  logic [IDW-1:0]  last_q,  last_d;
  logic [CW-1:0]   beat_q,  beat_d;

  logic            any_req;
  logic [IDW-1:0]  pick;
  logic            xfer;
  logic            active;
  logic [DATA_WIDTH-1:0] slice [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign slice[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_picker #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_picker (
    .req_i        (req_valid),
    .last_grant_i (last_q),
    .any_req_o    (any_req),
    .pick_o       (pick)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      last_q  <= IDW'(NREQ - 1);
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    beat_d  = beat_q;
    xfer    = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (any_req) begin
          grant_d = pick;
          beat_d  = '0;
          state_d = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        xfer = req_valid[grant_q] & ~fifo_full;
        if (xfer) beat_d = beat_q + 1'b1;
        if (!req_valid[grant_q] || (xfer && (beat_q == CW'(BURST - 1)))) begin
          last_d  = grant_q;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Gating by reset keeps the write port quiet in a cycle that abandons a grant.
  assign active      = reset && (state_q == ARB_GRANT);
  assign busy        = active;
  assign grant_id    = grant_q;
  assign fifo_write  = active & xfer;
  assign req_ready   = fifo_write ? (NREQ'(1) << grant_q) : '0;
  assign fifo_datain = active ? {grant_q, slice[grant_q]} : '0;

endmodule
`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_fifo_write_arbiter
// Brief    : Directed self-checking bench for fifo_write_arbiter (NREQ=4 and NREQ=3)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_fifo_write_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_write;
  logic [9:0]  fifo_datain;
  logic        fifo_full;
  logic [1:0]  grant_id;
  logic        busy;

  logic        rst3;
  logic [2:0]  v3;
  logic [23:0] d3;
  logic [2:0]  r3;
  logic        w3;
  logic [9:0]  din3;
  logic        full3;
  logic [1:0]  g3;
  logic        b3;

  int errors = 0;
  int checks = 0;

  fifo_write_arbiter #(.NREQ(4), .DATA_WIDTH(8), .BURST(4)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .fifo_write  (fifo_write),
    .fifo_datain (fifo_datain),
    .fifo_full   (fifo_full),
    .grant_id    (grant_id),
    .busy        (busy)
  );

  fifo_write_arbiter #(.NREQ(3), .DATA_WIDTH(8), .BURST(4)) u_dut3 (
    .clk         (clk),
    .reset       (rst3),
    .req_valid   (v3),
    .req_data    (d3),
    .req_ready   (r3),
    .fifo_write  (w3),
    .fifo_datain (din3),
    .fifo_full   (full3),
    .grant_id    (g3),
    .busy        (b3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] data_of(input int g);
    return 8'(8'hA0 + g * 8'h11);
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic exp_main(input string tag, input bit b, input bit w, input logic [3:0] r, input int g);
    #1;
    check({tag, ".busy"},  32'(busy),       32'(b));
    check({tag, ".write"}, 32'(fifo_write), 32'(w));
    check({tag, ".ready"}, 32'(req_ready),  32'(r));
    if (b) begin
      check({tag, ".gid"},  32'(grant_id),    32'(g));
      check({tag, ".data"}, 32'(fifo_datain), 32'({2'(g), data_of(g)}));
    end
  endtask

  task automatic exp3(input string tag, input bit b, input bit w, input logic [2:0] r, input int g);
    #1;
    check({tag, ".busy"},  32'(b3), 32'(b));
    check({tag, ".write"}, 32'(w3), 32'(w));
    check({tag, ".ready"}, 32'(r3), 32'(r));
    if (b) begin
      check({tag, ".gid"},  32'(g3),   32'(g));
      check({tag, ".data"}, 32'(din3), 32'({2'(g), data_of(g)}));
    end
  endtask

  // One idle arbitration cycle followed by a full burst of four beats from g.
  task automatic burst_main(input string tag, input int g);
    exp_main({tag, ".idle"}, 1'b0, 1'b0, 4'b0000, 0);
    tick();
    for (int b = 0; b < 4; b++) begin
      exp_main($sformatf("%s.beat%0d", tag, b), 1'b1, 1'b1, 4'(1 << g), g);
      tick();
    end
  endtask

  task automatic burst3(input string tag, input int g);
    exp3({tag, ".idle"}, 1'b0, 1'b0, 3'b000, 0);
    tick();
    for (int b = 0; b < 4; b++) begin
      exp3($sformatf("%s.beat%0d", tag, b), 1'b1, 1'b1, 3'(1 << g), g);
      tick();
    end
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    tick();
    exp_main({tag, ".rst"}, 1'b0, 1'b0, 4'b0000, 0);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    reset     = 1'b0;
    req_valid = 4'b1111;
    fifo_full = 1'b0;
    for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = data_of(i);
    rst3  = 1'b0;
    v3    = 3'b000;
    full3 = 1'b0;
    for (int i = 0; i < 3; i++) d3[i*8 +: 8] = data_of(i);

    // All four requesting from reset: 0,1,2,3 then back to 0.
    do_reset("t1");
    burst_main("t1.g0", 0);
    burst_main("t1.g1", 1);
    burst_main("t1.g2", 2);
    burst_main("t1.g3", 3);
    burst_main("t1.g0b", 0);

    // Lone requester 2: four writes, one idle, repeating.
    req_valid = 4'b0100;
    do_reset("t2");
    burst_main("t2.a", 2);
    burst_main("t2.b", 2);
    exp_main("t2.idle", 1'b0, 1'b0, 4'b0000, 0);

    // Requester 1 stalled by fifo_full for three cycles after beat 2.
    req_valid = 4'b0010;
    do_reset("t3");
    exp_main("t3.idle", 1'b0, 1'b0, 4'b0000, 0);
    tick();
    exp_main("t3.beat1", 1'b1, 1'b1, 4'b0010, 1);
    tick();
    exp_main("t3.beat2", 1'b1, 1'b1, 4'b0010, 1);
    tick();
    fifo_full = 1'b1;
    for (int s = 0; s < 3; s++) begin
      exp_main($sformatf("t3.stall%0d", s), 1'b1, 1'b0, 4'b0000, 1);
      tick();
    end
    fifo_full = 1'b0;
    exp_main("t3.beat3", 1'b1, 1'b1, 4'b0010, 1);
    tick();
    exp_main("t3.beat4", 1'b1, 1'b1, 4'b0010, 1);
    tick();
    exp_main("t3.release", 1'b0, 1'b0, 4'b0000, 0);

    // Requester 3 drops valid after one beat; next grant wraps to 0.
    req_valid = 4'b1000;
    do_reset("t4");
    exp_main("t4.idle", 1'b0, 1'b0, 4'b0000, 0);
    tick();
    exp_main("t4.beat1", 1'b1, 1'b1, 4'b1000, 3);
    tick();
    req_valid = 4'b0011;
    exp_main("t4.drop", 1'b1, 1'b0, 4'b0000, 3);
    tick();
    exp_main("t4.idle2", 1'b0, 1'b0, 4'b0000, 0);
    tick();
    exp_main("t4.wrap", 1'b1, 1'b1, 4'b0001, 0);

    // Reset mid-burst on 2 after 1 has been served: priority restarts at 0.
    req_valid = 4'b0010;
    do_reset("t5");
    burst_main("t5.g1", 1);
    req_valid = 4'b0100;
    exp_main("t5.idle", 1'b0, 1'b0, 4'b0000, 0);
    tick();
    exp_main("t5.beat1", 1'b1, 1'b1, 4'b0100, 2);
    tick();
    exp_main("t5.beat2", 1'b1, 1'b1, 4'b0100, 2);
    tick();
    reset = 1'b0;
    exp_main("t5.midrst", 1'b0, 1'b0, 4'b0000, 0);
    tick();
    reset     = 1'b1;
    req_valid = 4'b0110;
    exp_main("t5.idle2", 1'b0, 1'b0, 4'b0000, 0);
    tick();
    exp_main("t5.repick", 1'b1, 1'b1, 4'b0010, 1);

    // NREQ=3, all valid: 0,1,2,0 with IDs staying in range.
    v3 = 3'b111;
    tick();
    exp3("t6.rst", 1'b0, 1'b0, 3'b000, 0);
    rst3 = 1'b1;
    burst3("t6.g0", 0);
    burst3("t6.g1", 1);
    burst3("t6.g2", 2);
    burst3("t6.g0b", 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
